// File: rtl/sched_pkg.sv
// Shared types for the round-robin job scheduler: FSM state encoding and a debug name helper.
package sched_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StBusy  = 2'd2,
        StAck   = 2'd3
    } sched_state_e;

    // Five ASCII characters, space padded, for waveform viewers and debug prints.
    function automatic logic [39:0] state_name(input sched_state_e s);
        logic [39:0] v_name;
        v_name = "?????";
        unique case (s)
            StIdle:  v_name = "IDLE ";
            StIssue: v_name = "ISSUE";
            StBusy:  v_name = "BUSY ";
            StAck:   v_name = "ACK  ";
            default: v_name = "?????";
        endcase
        return v_name;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after i_rr_ptr, wrapping at N_REQ-1.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned SEL_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_rr_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [SEL_W-1:0] o_gnt_idx
);

    logic [SEL_W:0]   w_sum;
    logic [SEL_W-1:0] w_pos;
    logic             w_found;

    // One extra bit holds ptr+i (at most 2*N_REQ-2) before the modulo fold.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_sum     = '0;
        w_pos     = '0;
        w_found   = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, i_rr_ptr} + (SEL_W + 1)'(i);
            if (w_sum >= (SEL_W + 1)'(N_REQ)) begin
                w_sum = w_sum - (SEL_W + 1)'(N_REQ);
            end
            w_pos = w_sum[SEL_W-1:0];
            if (!w_found && i_req[w_pos]) begin
                w_found      = 1'b1;
                o_gnt_idx    = w_pos;
                o_gnt[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_job_scheduler.sv
// Round-robin sharing of one start/done compute engine among N_REQ requesters.
// Optional BUSY watchdog enabled by defining SCHED_TIMEOUT_EN.
module rr_job_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16,
    localparam int unsigned SEL_W         = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic             eng_start,
    output logic [SEL_W-1:0] eng_sel,
    input  logic             eng_done,
    output logic             busy,
    output logic             err
);

    if (N_REQ < 2 || N_REQ > 16) begin : gen_bad_n_req
        $error("rr_job_scheduler: N_REQ must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || $clog2(TIMEOUT_CYCLES + 1) > CNT_W) begin : gen_bad_timeout
        $error("rr_job_scheduler: TIMEOUT_CYCLES must be >= 1 and fit in CNT_W bits");
    end

    sched_state_e     r_state, w_state_d;
    logic [SEL_W-1:0] r_rr_ptr, w_rr_ptr_d;
    logic [SEL_W-1:0] r_eng_sel, w_eng_sel_d;
    logic [N_REQ-1:0] w_gnt;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_gnt_valid;
    logic             w_expire;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arbiter (
        .i_req     (req),
        .i_rr_ptr  (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_gnt_valid = |w_gnt;

`ifdef SCHED_TIMEOUT_EN
    logic [CNT_W-1:0] r_wdog, w_wdog_d;
    logic             r_err;

    // Done arriving in the expiry cycle wins, so expiry requires eng_done low.
    assign w_expire = (r_state == StBusy) && !eng_done
                      && (r_wdog == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_wdog_d = r_wdog;
        if (r_state == StIssue) begin
            w_wdog_d = '0;
        end else if (r_state == StBusy) begin
            w_wdog_d = r_wdog + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= w_wdog_d;
            r_err  <= w_expire;
        end
    end

    assign err = (r_state == StAck) && r_err;
`else
    assign w_expire = 1'b0;
    assign err      = 1'b0;
`endif

    always_comb begin
        w_state_d   = r_state;
        w_rr_ptr_d  = r_rr_ptr;
        w_eng_sel_d = r_eng_sel;
        unique case (r_state)
            StIdle: begin
                if (w_gnt_valid) begin
                    w_eng_sel_d = w_gnt_idx;
                    w_rr_ptr_d  = (w_gnt_idx == SEL_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                    w_state_d   = StIssue;
                end
            end
            StIssue: w_state_d = StBusy;
            StBusy: begin
                if (eng_done || w_expire) begin
                    w_state_d = StAck;
                end
            end
            StAck:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_rr_ptr  <= '0;
            r_eng_sel <= '0;
        end else begin
            r_state   <= w_state_d;
            r_rr_ptr  <= w_rr_ptr_d;
            r_eng_sel <= w_eng_sel_d;
        end
    end

    // Outputs decode registered state only; eng_sel is stable from ISSUE through ACK.
    assign eng_start = (r_state == StIssue);
    assign busy      = (r_state != StIdle);
    assign eng_sel   = r_eng_sel;

    always_comb begin
        ack = '0;
        if (r_state == StAck) begin
            ack[r_eng_sel] = 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_job_scheduler.sv
// Directed self-checking bench for rr_job_scheduler (N_REQ=4, TIMEOUT_CYCLES=8).
module tb_rr_job_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ack;
    logic       eng_start;
    logic [1:0] eng_sel;
    logic       eng_done;
    logic       busy;
    logic       err;

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] want;

    always #5 clk = ~clk;

    rr_job_scheduler #(
        .N_REQ          (4),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .eng_start (eng_start),
        .eng_sel   (eng_sel),
        .eng_done  (eng_done),
        .busy      (busy),
        .err       (err)
    );

    // Packed view {busy, eng_start, eng_sel, ack, err}.
    function automatic logic [8:0] obs();
        return {busy, eng_start, eng_sel, ack, err};
    endfunction

    function automatic logic [8:0] ev(input logic b, input logic s, input logic [1:0] sel,
                                      input logic [3:0] a, input logic e);
        return {b, s, sel, a, e};
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        req      = 4'b0000;
        eng_done = 1'b0;
        repeat (2) cyc();
        want = ev(1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL reset: got %b want %b", obs(), want);
        end
        rst = 1'b0;
        cyc();
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL idle_after_reset: got %b want %b", obs(), want);
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        cyc();
        want = ev(1'b1, 1'b1, 2'd2, 4'b0000, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL single_issue: got %b want %b", obs(), want);
        end
        want = ev(1'b1, 1'b0, 2'd2, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_vec++;
            if (obs() !== want) begin
                n_err++; $display("FAIL single_busy%0d: got %b want %b", i, obs(), want);
            end
        end
        eng_done = 1'b1;
        cyc();
        want = ev(1'b1, 1'b0, 2'd2, 4'b0100, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL single_ack: got %b want %b", obs(), want);
        end
        eng_done = 1'b0;
        req      = 4'b0000;
        cyc();
        want = ev(1'b0, 1'b0, 2'd2, 4'b0000, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL single_idle: got %b want %b", obs(), want);
        end
    endtask

    // Starts with rr_ptr=3 left by test_single; also holds eng_done into IDLE/ISSUE.
    task automatic test_wrap();
        req = 4'b1001;
        cyc();
        want = ev(1'b1, 1'b1, 2'd3, 4'b0000, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL wrap_issue3: got %b want %b", obs(), want);
        end
        cyc();
        eng_done = 1'b1;
        cyc();
        want = ev(1'b1, 1'b0, 2'd3, 4'b1000, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL wrap_ack3: got %b want %b", obs(), want);
        end
        req = 4'b0001;
        cyc();
        want = ev(1'b0, 1'b0, 2'd3, 4'b0000, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL wrap_idle_done_held: got %b want %b", obs(), want);
        end
        cyc();
        want = ev(1'b1, 1'b1, 2'd0, 4'b0000, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL wrap_issue0: got %b want %b", obs(), want);
        end
        eng_done = 1'b0;
        want = ev(1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_vec++;
            if (obs() !== want) begin
                n_err++; $display("FAIL done_in_issue_ignored%0d: got %b want %b", i, obs(), want);
            end
        end
        eng_done = 1'b1;
        cyc();
        want = ev(1'b1, 1'b0, 2'd0, 4'b0001, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL wrap_ack0: got %b want %b", obs(), want);
        end
        eng_done = 1'b0;
        req      = 4'b0000;
        cyc();
        want = ev(1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL wrap_idle: got %b want %b", obs(), want);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_sel = 2'(g % 4);
            cyc();
            want = ev(1'b1, 1'b1, exp_sel, 4'b0000, 1'b0);
            n_vec++;
            if (obs() !== want) begin
                n_err++; $display("FAIL rr_issue%0d: got %b want %b", g, obs(), want);
            end
            cyc();
            cyc();
            want = ev(1'b1, 1'b0, exp_sel, 4'b0000, 1'b0);
            n_vec++;
            if (obs() !== want) begin
                n_err++; $display("FAIL rr_busy%0d: got %b want %b", g, obs(), want);
            end
            eng_done = 1'b1;
            cyc();
            want = ev(1'b1, 1'b0, exp_sel, 4'b0001 << exp_sel, 1'b0);
            n_vec++;
            if (obs() !== want) begin
                n_err++; $display("FAIL rr_ack%0d: got %b want %b", g, obs(), want);
            end
            eng_done = 1'b0;
            cyc();
            want = ev(1'b0, 1'b0, exp_sel, 4'b0000, 1'b0);
            n_vec++;
            if (obs() !== want) begin
                n_err++; $display("FAIL rr_idle%0d: got %b want %b", g, obs(), want);
            end
            if (g == 4) req = 4'b0000;
        end
    endtask

    task automatic test_reset_abort();
        req = 4'b0010;
        cyc();
        want = ev(1'b1, 1'b1, 2'd1, 4'b0000, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL abort_issue: got %b want %b", obs(), want);
        end
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        want = ev(1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL abort_async: got %b want %b", obs(), want);
        end
        cyc();
        rst      = 1'b0;
        req      = 4'b0000;
        eng_done = 1'b1;
        cyc();
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL abort_no_ack: got %b want %b", obs(), want);
        end
        // Reset rr_ptr is 0, so 0110 must grant 1 (a stale ptr of 2 would grant 2).
        eng_done = 1'b0;
        req      = 4'b0110;
        cyc();
        want = ev(1'b1, 1'b1, 2'd1, 4'b0000, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL abort_ptr_reset: got %b want %b", obs(), want);
        end
        req = 4'b0000;
        cyc();
        eng_done = 1'b1;
        cyc();
        want = ev(1'b1, 1'b0, 2'd1, 4'b0010, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL abort_next_ack: got %b want %b", obs(), want);
        end
        eng_done = 1'b0;
        cyc();
    endtask

`ifdef SCHED_TIMEOUT_EN
    task automatic test_timeout();
        req = 4'b0001;
        cyc();
        want = ev(1'b1, 1'b1, 2'd0, 4'b0000, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL tmo_issue: got %b want %b", obs(), want);
        end
        req  = 4'b0000;
        want = ev(1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_vec++;
            if (obs() !== want) begin
                n_err++; $display("FAIL tmo_busy%0d: got %b want %b", i, obs(), want);
            end
        end
        cyc();
        want = ev(1'b1, 1'b0, 2'd0, 4'b0001, 1'b1);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL tmo_ack_err: got %b want %b", obs(), want);
        end
        cyc();
        want = ev(1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL tmo_idle: got %b want %b", obs(), want);
        end
    endtask

    task automatic test_done_at_expiry();
        req = 4'b0010;
        cyc();
        req  = 4'b0000;
        want = ev(1'b1, 1'b0, 2'd1, 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_vec++;
            if (obs() !== want) begin
                n_err++; $display("FAIL expiry_busy%0d: got %b want %b", i, obs(), want);
            end
        end
        eng_done = 1'b1;
        cyc();
        want = ev(1'b1, 1'b0, 2'd1, 4'b0010, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL expiry_done_no_err: got %b want %b", obs(), want);
        end
        eng_done = 1'b0;
        cyc();
    endtask
`else
    task automatic test_no_timeout();
        req = 4'b0001;
        cyc();
        req  = 4'b0000;
        want = ev(1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc();
            n_vec++;
            if (obs() !== want) begin
                n_err++; $display("FAIL no_tmo_busy%0d: got %b want %b", i, obs(), want);
            end
        end
        eng_done = 1'b1;
        cyc();
        want = ev(1'b1, 1'b0, 2'd0, 4'b0001, 1'b0);
        n_vec++;
        if (obs() !== want) begin
            n_err++; $display("FAIL no_tmo_ack: got %b want %b", obs(), want);
        end
        eng_done = 1'b0;
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_reset();
        test_round_robin();
        test_reset_abort();
`ifdef SCHED_TIMEOUT_EN
        test_reset();
        test_timeout();
        test_done_at_expiry();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
